// File: rtl/sccb_target.sv
// SCCB write target with a 256x8 register file and a registered debug read port.
// Define SCCB_READ_EN to also answer read IDs (SID|1) from the last received address.
module sccb_target #(
   parameter logic [7:0] SID = 8'h60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sioc,
   inout  wire        siod,
   output logic       wr_strobe,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       busy,
   input  logic [7:0] dbg_addr,
   output logic [7:0] dbg_data
);

   typedef enum logic [3:0] {
      IDLE, ID, ACK_ID, REG, ACK_REG, DATA, ACK_DATA, WAIT_STOP, RD_DATA, RD_ACK
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] sioc_sync_q, siod_sync_q;
   logic       sioc_prev_q, siod_prev_q;
   logic [1:0] arm_q;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic       sda_oe_q, sda_oe_d;
   logic       ack_hold_q, ack_hold_d;
   logic [7:0] reg_addr_q, reg_addr_d;
   logic       wr_strobe_d;
   logic [7:0] wr_addr_d, wr_data_d;
   logic [7:0] mem [256];
   logic       mem_we;
`ifdef SCCB_READ_EN
   logic       rd_mode_q, rd_mode_d;
   logic [7:0] rd_shift_q, rd_shift_d;
`endif

   logic       sioc_s, siod_s, armed;
   logic       sioc_rise, sioc_fall, start_det, stop_det, last_bit;
   logic [7:0] byte_in;

   assign sioc_s    = sioc_sync_q[1];
   assign siod_s    = siod_sync_q[1];
   // Edges only count once the whole sync/prev pipeline holds post-reset samples.
   assign armed     = (arm_q == 2'd3);
   assign sioc_rise = armed & sioc_s & ~sioc_prev_q;
   assign sioc_fall = armed & ~sioc_s & sioc_prev_q;
   assign start_det = armed & sioc_s & sioc_prev_q & siod_prev_q & ~siod_s;
   assign stop_det  = armed & sioc_s & sioc_prev_q & ~siod_prev_q & siod_s;
   assign byte_in   = {shift_q[6:0], siod_s};
   assign last_bit  = sioc_rise & (bit_cnt_q == 4'd7);

   assign siod = sda_oe_q ? 1'b0 : 1'bz;
   assign busy = (state_q != IDLE);

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      sda_oe_d    = sda_oe_q;
      ack_hold_d  = ack_hold_q;
      reg_addr_d  = reg_addr_q;
      wr_strobe_d = 1'b0;
      wr_addr_d   = wr_addr;
      wr_data_d   = wr_data;
      mem_we      = 1'b0;
`ifdef SCCB_READ_EN
      rd_mode_d   = rd_mode_q;
      rd_shift_d  = rd_shift_q;
`endif
      if (stop_det) begin
         state_d  = IDLE;
         sda_oe_d = 1'b0;
      end else if (start_det) begin
         state_d    = ID;
         sda_oe_d   = 1'b0;
         bit_cnt_d  = '0;
         shift_d    = '0;
         ack_hold_d = 1'b0;
`ifdef SCCB_READ_EN
         rd_mode_d  = 1'b0;
`endif
      end else begin
         if (sioc_rise && (state_q inside {ID, REG, DATA})) begin
            shift_d   = byte_in;
            bit_cnt_d = last_bit ? 4'd0 : bit_cnt_q + 4'd1;
         end
         case (state_q)
            ID: if (last_bit) begin
               if (byte_in == SID) state_d = ACK_ID;
`ifdef SCCB_READ_EN
               else if (byte_in == (SID | 8'h01)) begin
                  state_d   = ACK_ID;
                  rd_mode_d = 1'b1;
               end
`endif
               else state_d = WAIT_STOP;
            end
            REG: if (last_bit) begin
               reg_addr_d = byte_in;
               state_d    = ACK_REG;
            end
            DATA: if (last_bit) begin
               mem_we      = 1'b1;
               wr_strobe_d = 1'b1;
               wr_addr_d   = reg_addr_q;
               wr_data_d   = byte_in;
               state_d     = ACK_DATA;
            end
            ACK_ID, ACK_REG, ACK_DATA: if (sioc_fall) begin
               // First fall after the byte starts the ACK low, the next one ends it.
               sda_oe_d   = ~ack_hold_q;
               ack_hold_d = ~ack_hold_q;
               if (ack_hold_q) begin
                  if (state_q == ACK_REG) state_d = DATA;
                  else if (state_q == ACK_DATA) state_d = WAIT_STOP;
                  else begin
`ifdef SCCB_READ_EN
                     if (rd_mode_q) begin
                        state_d    = RD_DATA;
                        rd_shift_d = mem[reg_addr_q];
                        sda_oe_d   = ~mem[reg_addr_q][7];
                     end else
`endif
                     state_d = REG;
                  end
               end
            end
`ifdef SCCB_READ_EN
            RD_DATA: begin
               if (sioc_rise) bit_cnt_d = bit_cnt_q + 4'd1;
               if (sioc_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     sda_oe_d  = 1'b0;
                     bit_cnt_d = '0;
                     state_d   = RD_ACK;
                  end else begin
                     rd_shift_d = {rd_shift_q[6:0], 1'b0};
                     sda_oe_d   = ~rd_shift_q[6];
                  end
               end
            end
            RD_ACK: if (sioc_rise) state_d = WAIT_STOP;
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         sioc_sync_q <= 2'b11;
         siod_sync_q <= 2'b11;
         sioc_prev_q <= 1'b1;
         siod_prev_q <= 1'b1;
         arm_q       <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         sda_oe_q    <= 1'b0;
         ack_hold_q  <= 1'b0;
         reg_addr_q  <= '0;
         wr_strobe   <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
         dbg_data    <= '0;
`ifdef SCCB_READ_EN
         rd_mode_q   <= 1'b0;
         rd_shift_q  <= '0;
`endif
      end else begin
         state_q     <= state_d;
         sioc_sync_q <= {sioc_sync_q[0], sioc};
         siod_sync_q <= {siod_sync_q[0], siod};
         sioc_prev_q <= sioc_s;
         siod_prev_q <= siod_s;
         if (!armed) arm_q <= arm_q + 2'd1;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         sda_oe_q    <= sda_oe_d;
         ack_hold_q  <= ack_hold_d;
         reg_addr_q  <= reg_addr_d;
         wr_strobe   <= wr_strobe_d;
         wr_addr     <= wr_addr_d;
         wr_data     <= wr_data_d;
         dbg_data    <= mem[dbg_addr];
`ifdef SCCB_READ_EN
         rd_mode_q   <= rd_mode_d;
         rd_shift_q  <= rd_shift_d;
`endif
      end
   end

   // Register file keeps its contents through reset.
   always_ff @(posedge clk) begin
      if (mem_we && !reset) mem[reg_addr_q] <= byte_in;
   end

endmodule

// File: doc/sccb_target.md
SCCB_TARGET -- requirements
Module: sccb_target

Interface
REQ-001 SHALL have parameter SID, default 8'h60, meaning 8-bit write device ID (bit0 = 0) this target answers to.
REQ-002 SHALL have port clk  input  1  system clock (50 MHz); all logic on rising edge.
REQ-003 SHALL have port reset  input  1  one clock; reset is synchronous and active-high.
REQ-004 SHALL have port sioc  input  1  SCCB clock from master.
REQ-005 SHALL have port siod  inout  1  SCCB data; target drives only 0 or high-Z, never 1.
REQ-006 SHALL have port wr_strobe  output  1  one-cycle pulse on register write commit.
REQ-007 SHALL have port wr_addr  output  8  register address of last commit.
REQ-008 SHALL have port wr_data  output  8  data byte of last commit.
REQ-009 SHALL have port busy  output  1  high from START until STOP or abort.
REQ-010 SHALL have port dbg_addr  input  8  register file read address.
REQ-011 SHALL have port dbg_data  output  8  register file contents at dbg_addr, registered, 1-cycle latency.

Function
REQ-012 SHALL pass sioc/siod through 2-flop synchronizers; edge/START/STOP detection on synchronized, previous-sample pairs (total detection latency 3 clk).
REQ-013 SHALL detect START as siod falling while sioc high, and STOP as siod rising while sioc high.
REQ-014 SHALL sample data bits on sioc rising edge, MSB first, 8 bits per phase.
REQ-015 SHALL use states IDLE, ID, ACK_ID, REG, ACK_REG, DATA, ACK_DATA, WAIT_STOP (plus RD_DATA, RD_ACK under REQ-027).
REQ-016 SHALL transition IDLE->ID on START; ID->ACK_ID when 8 bits equal SID; ID->WAIT_STOP on mismatch, with siod never driven.
REQ-017 SHALL, in each ACK_* state, drive siod low from the first sioc falling edge after the 8th bit until the following sioc falling edge, then release.
REQ-018 SHALL advance ACK_ID->REG, ACK_REG->DATA, ACK_DATA->WAIT_STOP.
REQ-019 SHALL, on entering ACK_DATA, write data to 256x8 register file at received address and pulse wr_strobe for exactly 1 clk with wr_addr/wr_data valid that cycle.
REQ-020 SHALL ignore further bytes in WAIT_STOP (no ACK, no write).
REQ-021 SHALL, on STOP in any state, go to IDLE, release siod, deassert busy; STOP before DATA completes produces no write.
REQ-022 SHALL, on repeated START in any non-IDLE state, release siod and restart in ID.
REQ-023 SHALL give a simultaneous dbg_addr read and write to the same address the old data (read-before-write).

Reset
REQ-024 SHALL, on reset (including mid-transaction), go to IDLE, release siod, clear wr_strobe, busy, wr_addr, wr_data, dbg_data, bit counter and shift register to 0.
REQ-025 SHALL leave register file contents unaffected by reset.
REQ-026 SHALL ignore START/STOP conditions spanning reset deassertion; the first START fully seen after reset low is honoured.

Configuration
REQ-027 SHALL, with SCCB_READ_EN defined, accept ID equal to SID|1, ACK it, then in RD_DATA drive register file[last received address] MSB first, changing siod after each sioc falling edge (0 = drive low, 1 = release); then in RD_ACK release siod and go to WAIT_STOP regardless of master ACK/NA.
REQ-028 SHALL, with SCCB_READ_EN defined, latch the address on a 2-phase write (ID+REG then STOP) without a register write.
REQ-029 SHALL, without SCCB_READ_EN, treat SID|1 as ID mismatch (no ACK, WAIT_STOP); 2-phase write has no effect.

Verification
REQ-030 SHALL cover: 3-phase write ID 0x60, REG 0x12, DATA 0x80 -> three ACK lows, one wr_strobe with wr_addr=0x12, wr_data=0x80; dbg_addr=0x12 gives 0x80.
REQ-031 SHALL cover: ID 0x42 followed by 2 bytes -> siod never driven low, no wr_strobe, busy drops at STOP.
REQ-032 SHALL cover: STOP after REG 0xFF -> no wr_strobe, register 0xFF unchanged, state IDLE.
REQ-033 SHALL cover: reset asserted mid DATA byte -> siod released next clk, busy=0; subsequent write 0x05<-0xAA commits normally.
REQ-034 SHALL cover: repeated START during REG phase then full write 0x20<-0x3C -> single strobe with 0x20/0x3C.
REQ-035 SHALL cover with SCCB_READ_EN: write 0x0A<-0x5A, 2-phase 0x0A, read ID 0x61 -> target shifts 0x5A on siod; without macro 0x61 gets no ACK.
